// File: rtl/d_ff_behavioral.sv
// Parameterised D flip-flop with synchronous active-low reset and synchronous
// active-high set. The complemented output is derived combinationally from the registered value.
module d_ff_behavioral #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] d,
    input  logic             set,
    input  logic             reset,
    input  logic             clk
);

    // Reset outranks set, and set outranks data. X on set or d is harmless while a higher-priority control holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (set) begin
            q <= '1;
        end else begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_d_ff_behavioral.sv
// Directed bench for d_ff_behavioral: a 1-bit instance and a 4-bit instance share
// clk, set and reset. A vector table is followed by hand-written sequences for mid-cycle behaviour.
module tb_d_ff_behavioral;

    logic       clk = 1'b0;
    logic       reset;
    logic       set;
    logic       d;
    logic [3:0] d4;
    logic       q,  qbar;
    logic [3:0] q4, qbar4;

    int n_vec  = 0;
    int n_miss = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    d_ff_behavioral #(.WIDTH(1)) dut1 (
        .q(q), .qbar(qbar), .d(d), .set(set), .reset(reset), .clk(clk)
    );

    d_ff_behavioral #(.WIDTH(4)) dut4 (
        .q(q4), .qbar(qbar4), .d(d4), .set(set), .reset(reset), .clk(clk)
    );

    typedef struct {
        logic       reset;
        logic       set;
        logic       d;
        logic [3:0] d4;
        logic       exp_q;
        logic [3:0] exp_q4;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic eq, input logic [3:0] eq4);
        check({tag, ".q"},     {3'b000, q},    {3'b000, eq});
        check({tag, ".qbar"},  {3'b000, qbar}, {3'b000, ~eq});
        check({tag, ".q4"},    q4,             eq4);
        check({tag, ".qbar4"}, qbar4,          ~eq4);
    endtask

    task automatic drive(input logic r, input logic s, input logic dd, input logic [3:0] dd4);
        reset = r;
        set   = s;
        d     = dd;
        d4    = dd4;
    endtask

    task automatic add(input logic r, input logic s, input logic dd, input logic [3:0] dd4,
                       input logic eq, input logic [3:0] eq4, input int reps);
        vec_t v;
        v.reset = r; v.set = s; v.d = dd; v.d4 = dd4; v.exp_q = eq; v.exp_q4 = eq4;
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endtask

    // Complement relation checked on every falling edge once the registers hold a value.
    always @(negedge clk) begin
        if (started) begin
            check("inv.qbar",  {3'b000, qbar}, {3'b000, ~q});
            check("inv.qbar4", qbar4, ~q4);
        end
    end

    initial begin
        // reset with X on set and d
        add(1'b0, 1'bx, 1'bx, 4'bxxxx, 1'b0, 4'h0, 3);
        // set after reset release, d still X
        add(1'b1, 1'b1, 1'bx, 4'bxxxx, 1'b1, 4'hF, 3);
        // data capture
        add(1'b1, 1'b0, 1'b0, 4'hA,    1'b0, 4'hA, 3);
        add(1'b1, 1'b0, 1'b1, 4'h5,    1'b1, 4'h5, 3);
        // set overrides data
        add(1'b1, 1'b1, 1'b0, 4'h0,    1'b1, 4'hF, 3);
        // reset over set, then release back to set
        add(1'b0, 1'b1, 1'b1, 4'hF,    1'b0, 4'h0, 1);
        add(1'b1, 1'b1, 1'b0, 4'h0,    1'b1, 4'hF, 1);
        add(1'b1, 1'b0, 1'b1, 4'hC,    1'b1, 4'hC, 1);
        add(1'b1, 1'b0, 1'b0, 4'h3,    1'b0, 4'h3, 1);
        add(1'b0, 1'b0, 1'b1, 4'h6,    1'b0, 4'h0, 1);
        add(1'b1, 1'b0, 1'b1, 4'h6,    1'b1, 4'h6, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].reset, vecs[i].set, vecs[i].d, vecs[i].d4);
            @(posedge clk);
            #1;
            started = 1'b1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_q4);
            #1;
        end

        // Glitches between edges must not disturb q.
        drive(1'b1, 1'b0, 1'b1, 4'h9);
        @(posedge clk); #2;
        check_all("load9", 1'b1, 4'h9);
        reset = 1'b0; d = 1'b0; d4 = 4'h0; set = 1'b1;
        #1;
        check_all("glitch_mid", 1'b1, 4'h9);
        #2;
        drive(1'b1, 1'b0, 1'b1, 4'h9);
        #1;
        check_all("glitch_after", 1'b1, 4'h9);
        @(posedge clk); #1;
        check_all("glitch_edge", 1'b1, 4'h9);

        // Reset asserted mid-cycle clears only at the next edge.
        #1;
        reset = 1'b0;
        #2;
        check_all("rst_pending", 1'b1, 4'h9);
        @(posedge clk); #1;
        check_all("rst_applied", 1'b0, 4'h0);

        // Release returns control to d at the first edge with reset high.
        #1;
        drive(1'b1, 1'b0, 1'b1, 4'hB);
        @(posedge clk); #1;
        check_all("rst_release", 1'b1, 4'hB);

        // d changes between edges are ignored until the next edge.
        #1;
        d = 1'b0; d4 = 4'h2;
        #3;
        check_all("hold_d", 1'b1, 4'hB);
        @(posedge clk); #1;
        check_all("take_d", 1'b0, 4'h2);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
